uart_baud_ctrl: RTL

UART_BAUD_CTRL -- requirements
Module: uart_baud_ctrl

---
 rtl/uart_baud_ctrl_if.sv | 35 +++
 rtl/uart_baud_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_ctrl_if.sv
// ============================================================================
//  Module   : uart_baud_ctrl_if
//  Brief    : Bit-period configuration handshake and status pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_baud_ctrl_if;
    logic        cfg_valid;
    logic [15:0] cfg_bit_cycles;
    logic        cfg_ready;
    logic        cfg_done;
    logic        cfg_err;
    logic        cfg_forced;

    modport master (
        output cfg_valid,
        output cfg_bit_cycles,
        input  cfg_ready,
        input  cfg_done,
        input  cfg_err,
        input  cfg_forced
    );

    modport slave (
        input  cfg_valid,
        input  cfg_bit_cycles,
        output cfg_ready,
        output cfg_done,
        output cfg_err,
        output cfg_forced
    );
endinterface

`default_nettype wire

// File: rtl/uart_baud_ctrl.sv
// ============================================================================
//  Module   : uart_baud_ctrl
//  Brief    : Safely retunes UART tx/rx baud dividers; optional autobaud
//             measurement enabled by macro UART_BAUD_AUTOBAUD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_ctrl #(
    parameter int unsigned DEFAULT_BIT_CYCLES = 434,
    parameter int unsigned DRAIN_TIMEOUT      = 1000000
) (
    input  wire               clk_50mhz,
    input  wire               rst,
    uart_baud_ctrl_if.slave   cfg,
    input  wire               tx_busy,
    input  wire               rx_busy,
    input  wire               autobaud_req,
    input  wire               rxd,
    output logic              tx_hold,
    output logic              baud_rst,
    output logic [15:0]       tx_divider,
    output logic [15:0]       rx_divider
);

    localparam logic [15:0] c_def_bits = 16'(DEFAULT_BIT_CYCLES);
    localparam logic [15:0] c_def_tx   = c_def_bits - 16'd1;
    localparam logic [15:0] c_def_rx   = (c_def_bits >> 4) - 16'd1;
    localparam logic [31:0] c_timeout  = 32'(DRAIN_TIMEOUT);
    localparam logic [15:0] c_min_bits = 16'd16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AB_WAIT = 3'd1,
        AB_MEAS = 3'd2,
        DRAIN   = 3'd3,
        APPLY   = 3'd4,
        SETTLE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pending;
    logic [31:0] r_timer;
    logic        r_forced;
    logic [15:0] r_tx_divider;
    logic [15:0] r_rx_divider;
    logic        r_baud_rst;
    logic        r_done;
    logic        r_err;
    logic        r_forced_pulse;

    logic        w_req_fire;
    logic        w_req_short;
    logic [15:0] w_req_bits;
    logic        w_timeout;

`ifdef UART_BAUD_AUTOBAUD_EN
    logic        r_rxd_prev;
    logic [15:0] r_ab_cnt;

    // Count starts at 1 because the cycle that reveals the falling edge is
    // already the first low cycle of the start bit.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_rxd_prev <= 1'b1;
            r_ab_cnt   <= 16'd0;
        end else begin
            r_rxd_prev <= rxd;
            if (r_state == AB_WAIT) begin
                r_ab_cnt <= 16'd1;
            end else if (r_state == AB_MEAS && !rxd && r_ab_cnt != 16'hFFFF) begin
                r_ab_cnt <= r_ab_cnt + 16'd1;
            end
        end
    end
`else
    logic w_unused_ab;
    assign w_unused_ab = autobaud_req ^ rxd;
`endif

    always_comb begin
        w_next     = r_state;
        w_req_fire = 1'b0;
        w_req_bits = cfg.cfg_bit_cycles;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    w_req_fire = 1'b1;
                end
`ifdef UART_BAUD_AUTOBAUD_EN
                else if (autobaud_req) begin
                    w_next = AB_WAIT;
                end
`endif
            end
`ifdef UART_BAUD_AUTOBAUD_EN
            AB_WAIT: begin
                if (r_rxd_prev && !rxd) begin
                    w_next = AB_MEAS;
                end
            end
            AB_MEAS: begin
                if (rxd) begin
                    w_req_fire = 1'b1;
                    w_req_bits = r_ab_cnt;
                end
            end
`endif
            DRAIN: begin
                if (!tx_busy && !rx_busy) begin
                    w_next = APPLY;
                end else if (r_timer <= 32'd1) begin
                    // Counter hits zero on this edge: give up waiting.
                    w_next    = APPLY;
                    w_timeout = 1'b1;
                end
            end
            APPLY:   w_next = SETTLE;
            SETTLE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_req_short = (w_req_bits < c_min_bits);
        if (w_req_fire) begin
            w_next = w_req_short ? IDLE : DRAIN;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pending      <= 16'd0;
            r_timer        <= 32'd0;
            r_forced       <= 1'b0;
            r_tx_divider   <= c_def_tx;
            r_rx_divider   <= c_def_rx;
            r_baud_rst     <= 1'b1;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_forced_pulse <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_req_fire && !w_req_short) begin
                r_pending <= w_req_bits;
                r_timer   <= c_timeout;
            end else if (r_state == DRAIN && r_timer != 32'd0) begin
                r_timer <= r_timer - 32'd1;
            end

            if (w_timeout) begin
                r_forced <= 1'b1;
            end else if (r_state == SETTLE) begin
                r_forced <= 1'b0;
            end

            // Dividers only ever change on the edge entering APPLY.
            if (r_state == DRAIN && w_next == APPLY) begin
                r_tx_divider <= r_pending - 16'd1;
                r_rx_divider <= (r_pending >> 4) - 16'd1;
            end

            r_baud_rst     <= (w_next == APPLY);
            r_done         <= (w_next == SETTLE);
            r_forced_pulse <= (w_next == SETTLE) && r_forced;
            r_err          <= w_req_fire && w_req_short;
        end
    end

    assign cfg.cfg_ready  = (r_state == IDLE);
    assign cfg.cfg_done   = r_done;
    assign cfg.cfg_err    = r_err;
    assign cfg.cfg_forced = r_forced_pulse;
    assign tx_hold        = (r_state == DRAIN) || (r_state == APPLY) || (r_state == SETTLE);
    assign baud_rst       = r_baud_rst;
    assign tx_divider     = r_tx_divider;
    assign rx_divider     = r_rx_divider;

endmodule

`default_nettype wire
